// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that stalls the CPU and copies one 256-byte page to a fixed register
module oam_dma #(
  parameter logic [15:0] REG_ADDR  = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic        clkCPU,
  input  logic        n_reset,
  input  logic [15:0] sys_addr,
  input  logic [7:0]  sys_data_in,
  input  logic        sys_rw,
  output logic        sys_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data,
  output logic        dma_rw,
  output logic        dma_done
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  logic [2:0] r_state;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_byte;
  logic       r_parity;
  logic       r_done;
  logic       w_trigger;
  logic       w_write;
  assign w_trigger = !sys_rw && sys_addr == REG_ADDR;
  assign w_write   = r_state == S_WRITE;
  // sequencer: parity clock, trigger snoop, read/write pair stepping; HALT leaves on the parity that makes the first READ even
  always_ff @(posedge clkCPU or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= S_IDLE;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_byte   <= 8'h00;
      r_parity <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: if (w_trigger) begin
          r_page  <= sys_data_in;
          r_idx   <= 8'h00;
          r_state <= S_HALT;
        end
        S_HALT:  r_state <= r_parity ? S_READ : S_ALIGN;
        S_ALIGN: r_state <= S_READ;
        S_READ: begin
          r_byte  <= sys_data_in;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_idx   <= r_idx + 8'h01;
          r_state <= r_idx == 8'hFF ? S_IDLE : S_READ;
          r_done  <= r_idx == 8'hFF;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // bus outputs decoded from state so reset clears them without a clock
  always_comb begin
    dma_active = r_state == S_ALIGN || r_state == S_READ || w_write;
    dma_addr   = !dma_active ? 16'h0000 : w_write ? DEST_ADDR : {r_page, r_idx};
    dma_data   = w_write ? r_byte : 8'h00;
    dma_rw     = !w_write;
    sys_rdy    = r_state == S_IDLE;
    dma_done   = r_done;
  end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: random-timed transfers checked cycle by cycle against a page-copy trace model
module tb_oam_dma;
  logic        clkCPU = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] sys_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        sys_rw = 1'b1;
  logic [7:0]  sys_data_in;
  logic        sys_rdy, dma_active, dma_rw, dma_done;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  int          checks = 0;
  int          errors = 0;
  int          edges;
  localparam logic [27:0] IDLE_T = {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00};

  oam_dma dut (
    .clkCPU(clkCPU), .n_reset(n_reset), .sys_addr(sys_addr), .sys_data_in(sys_data_in),
    .sys_rw(sys_rw), .sys_rdy(sys_rdy), .dma_active(dma_active), .dma_addr(dma_addr),
    .dma_data(dma_data), .dma_rw(dma_rw), .dma_done(dma_done)
  );

  always #5 clkCPU = ~clkCPU;

  // memory answers DMA reads with low address byte ^ 5A; otherwise the CPU drives the bus
  assign sys_data_in = (dma_active && dma_rw) ? (dma_addr[7:0] ^ 8'h5A) : cpu_data;

  // clock edges since reset release; parity after edge n is n mod 2
  always @(posedge clkCPU or negedge n_reset) edges <= !n_reset ? 0 : edges + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] obs();
    return {sys_rdy, dma_active, dma_rw, dma_done, dma_addr, dma_data};
  endfunction

  function automatic logic [27:0] tup(input logic rdy, act, rw, done, input logic [15:0] a, input logic [7:0] d);
    return {rdy, act, rw, done, a, d};
  endfunction

  task automatic cpu_idle(input logic [15:0] a, input logic rw);
    @(negedge clkCPU);
    check("idle", obs(), IDLE_T);
    sys_addr = a;
    sys_rw = rw;
    cpu_data = 8'($urandom);
    if (!rw && a == 16'h4014) sys_rw = 1'b1;
  endtask

  // want: 1 = aligned start, 0 = unaligned start, 2 = whatever parity comes
  task automatic run_transfer(input logic [7:0] page, input int want, input bit inject, input int abort_at);
    logic [27:0] q[$];
    int pos[256];
    int stall = 0;
    bit aligned;
    @(negedge clkCPU);
    check("pre", obs(), IDLE_T);
    while (want != 2 && int'(edges % 2 == 0) != want) begin
      @(negedge clkCPU);
      check("pre", obs(), IDLE_T);
    end
    aligned = edges % 2 == 0;
    sys_addr = 16'h4014;
    sys_rw = 1'b0;
    cpu_data = page;
    q.push_back(tup(0, 0, 1, 0, 16'h0000, 8'h00));
    if (!aligned) q.push_back(tup(0, 1, 1, 0, {page, 8'h00}, 8'h00));
    for (int i = 0; i < 256; i++) begin
      q.push_back(tup(0, 1, 1, 0, {page, 8'(i)}, 8'h00));
      pos[i] = q.size();
      q.push_back(tup(0, 1, 0, 0, 16'h2004, 8'(i) ^ 8'h5A));
    end
    foreach (q[k]) begin
      @(negedge clkCPU);
      sys_rw = 1'b1;
      sys_addr = 16'($urandom);
      cpu_data = 8'($urandom);
      check("bus", obs(), q[k]);
      if (!sys_rdy) stall++;
      if (inject && k == pos[100]) begin
        sys_addr = 16'h4014;
        sys_rw = 1'b0;
        cpu_data = 8'h03;
      end
      if (abort_at >= 0 && k == pos[abort_at]) begin
        n_reset = 1'b0;
        #1 check("async_rst", obs(), IDLE_T);
        repeat (3) begin
          @(negedge clkCPU);
          check("in_rst", obs(), IDLE_T);
        end
        n_reset = 1'b1;
        repeat (3) begin
          @(negedge clkCPU);
          check("post_rst", obs(), IDLE_T);
        end
        return;
      end
    end
    check("stall", 64'(stall), aligned ? 64'd513 : 64'd514);
    @(negedge clkCPU);
    check("done", obs(), tup(1, 0, 1, 1, 16'h0000, 8'h00));
    @(negedge clkCPU);
    check("after", obs(), IDLE_T);
  endtask

  initial begin
    #1 check("reset", obs(), IDLE_T);
    @(negedge clkCPU);
    check("reset_hold", obs(), IDLE_T);
    n_reset = 1'b1;
    repeat (4) cpu_idle(16'($urandom), 1'($urandom));
    cpu_idle(16'h4014, 1'b1);
    cpu_idle(16'h4015, 1'b0);
    cpu_idle(16'h4014, 1'b1);
    cpu_idle(16'h4013, 1'b0);
    cpu_idle(16'h0000, 1'b1);
    run_transfer(8'h02, 1, 0, -1);
    repeat ($urandom_range(0, 3)) cpu_idle(16'($urandom), 1'b1);
    run_transfer(8'h02, 0, 0, -1);
    run_transfer(8'hFF, 2, 1, -1);
    run_transfer(8'($urandom), 2, 0, 99);
    run_transfer(8'h04, 2, 0, -1);
    repeat (2) begin
      repeat ($urandom_range(0, 5)) cpu_idle(16'($urandom), 1'($urandom));
      run_transfer(8'($urandom), 2, 1'($urandom), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter REG_ADDR, default 16'h4014, CPU write address that triggers a transfer.
REQ-002 Parameter DEST_ADDR, default 16'h2004, destination address written for every byte.
REQ-003 clkCPU  input  1  CPU bus clock; all state changes on its rising edge.
REQ-004 n_reset  input  1  reset, asynchronous, active-low.
REQ-005 sys_addr  input  16  CPU-driven address, snooped for trigger writes.
REQ-006 sys_data_in  input  8  resolved CPU data bus, read side.
REQ-007 sys_rw  input  1  CPU read/write; 1 = read, 0 = write.
REQ-008 sys_rdy  output  1  0 stalls the CPU; 1 releases it.
REQ-009 dma_active  output  1  1 = DMA owns the bus; top level muxes dma_addr, dma_data and dma_rw onto it.
REQ-010 dma_addr  output  16  DMA bus address.
REQ-011 dma_data  output  8  DMA write data.
REQ-012 dma_rw  output  1  DMA read/write; 1 = read, 0 = write.
REQ-013 dma_done  output  1  one-cycle pulse after the final write.

Function
REQ-014 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-015 Free-running parity bit: cleared by reset, toggles every clkCPU edge.
REQ-016 Trigger: in IDLE, an edge with sys_rw=0 and sys_addr==REG_ADDR latches page<=sys_data_in and idx<=0, then enters HALT.
REQ-017 A trigger edge drives sys_rdy=0 from the next cycle onward.
REQ-018 HALT lasts one cycle with dma_active=0, so the CPU completes its current access.
REQ-019 From HALT: next state READ if parity after the edge is 0 (even cycle); otherwise ALIGN.
REQ-020 ALIGN lasts one cycle with dma_active=1, dma_rw=1 and dma_addr={page,idx} (dummy read); next state READ.
REQ-021 READ: dma_active=1, dma_rw=1, dma_addr={page,idx}.
REQ-022 READ, on its closing edge: latch byte<=sys_data_in, then enter WRITE.
REQ-023 WRITE: dma_active=1, dma_rw=0, dma_addr=DEST_ADDR, dma_data=byte.
REQ-024 WRITE, on its closing edge: idx<=idx+1, 8-bit wrapping.
REQ-025 WRITE with idx==8'hFF goes to IDLE and pulses dma_done in the following cycle; otherwise it returns to READ.
REQ-026 Transfer length is exactly 256 READ/WRITE pairs: 513 stall cycles when aligned, 514 when not.
REQ-027 sys_rdy=0 in HALT, ALIGN, READ and WRITE; sys_rdy=1 in IDLE.
REQ-028 Trigger writes while not IDLE are ignored (the page is not relatched and the transfer is not restarted).
REQ-029 Page 8'hFF is legal: the final source address is 16'hFFFF.
REQ-030 When dma_active=0, dma_addr=16'h0000, dma_data=8'h00 and dma_rw=1.
REQ-031 A CPU read of REG_ADDR has no effect.

Reset
REQ-032 n_reset low forces, without waiting for a clock: state IDLE, page=0, idx=0, byte=0, parity=0, sys_rdy=1, dma_active=0, dma_addr=0, dma_data=0, dma_rw=1, dma_done=0.
REQ-033 Reset mid-transfer abandons the transfer; no further writes occur and dma_done does not pulse.
REQ-034 After reset release, the first trigger behaves per REQ-016.

Verification
REQ-035 Write 8'h02 to 16'h4014 on an even-parity edge -> HALT, READ 16'h0200, WRITE 16'h2004, ..., READ 16'h02FF, WRITE 16'h2004; sys_rdy low for 513 cycles; dma_done pulses once.
REQ-036 Same trigger on an odd-parity edge -> one ALIGN dummy read of 16'h0200 before the first READ; sys_rdy low for 514 cycles.
REQ-037 Memory model returns data = low address byte XOR 8'h5A -> the 256 writes carry 8'h5A, 8'h5B, ..., 8'hA5 in index order.
REQ-038 Page 8'hFF, plus a second trigger (data 8'h03) injected mid-transfer -> source addresses 16'hFF00 to 16'hFFFF only; the second trigger is ignored.
REQ-039 Assert n_reset at the 100th WRITE -> outputs reach reset values before the next clock; no dma_done; a new trigger of 8'h04 transfers 16'h0400 to 16'h04FF.
REQ-040 CPU read of 16'h4014 and a write to 16'h4015 -> no state change; sys_rdy stays 1.
